sprite_loader: RTL and testbench

//   Upstream feeder for sprite_storage. It turns a byte-stream packet from the host link into

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_loader.sv | 160 ++++++++++++++++
 tb/tb_sprite_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sizes, typedefs and FSM states for the sprite loader
package sprite_pkg;

  localparam int SPRITE_COUNT = 32;
  localparam int SEL_W        = 5;
  localparam int ADDR_W       = 14;
  localparam int DATA_W       = 8;
  localparam int SPRITE_BYTES = 8192;

  typedef logic [SEL_W-1:0]  sprite_sel_t;
  typedef logic [ADDR_W-1:0] nibble_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/sprite_loader.sv
// rtl/sprite_loader.sv - byte-stream packet to 4bpp sprite storage write port
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = sprite_pkg::SPRITE_COUNT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              abort,
  output logic [SEL_W-1:0]  w_select,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_select,
  output logic [ADDR_W-1:0] byte_count
);

  localparam nibble_addr_t FULL_COUNT = nibble_addr_t'(SPRITE_BYTES);
  localparam nibble_addr_t LAST_ADDR  = nibble_addr_t'(2 * SPRITE_BYTES - 2);

  loader_state_t     state_q, state_d;
  logic              s_ready_q, s_ready_d;
  sprite_sel_t       w_select_q, w_select_d;
  logic              w_en_q, w_en_d;
  nibble_addr_t      w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  nibble_addr_t      addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_select_q, err_select_d;
  nibble_addr_t      byte_count_q, byte_count_d;

  logic        abort_hit;
  logic        accept;
  sprite_sel_t hdr_sel;

  // abort kills acceptance combinationally so the byte on the abort cycle is never taken
  assign abort_hit = abort && (state_q != IDLE);
  assign s_ready   = s_ready_q && !abort_hit;
  assign accept    = s_valid && s_ready;
  assign hdr_sel   = s_data[SEL_W-1:0];

  always_comb begin
    state_d        = state_q;
    w_select_d     = w_select_q;
    w_en_d         = 1'b0;
    w_addr_d       = w_addr_q;
    w_data_d       = w_data_q;
    addr_d         = addr_q;
    err_overflow_d = err_overflow_q;
    err_select_d   = err_select_q;
    byte_count_d   = byte_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d         = '0;
          byte_count_d   = '0;
          err_overflow_d = 1'b0;
          if (int'(hdr_sel) >= NUM_SPRITES) begin
            err_select_d = 1'b1;
            state_d      = s_last ? DONE : DRAIN;
          end else begin
            err_select_d = 1'b0;
            w_select_d   = hdr_sel;
            state_d      = s_last ? DONE : LOAD;
          end
        end
      end
      LOAD: begin
        if (abort_hit) begin
          state_d = DONE;
        end else if (accept) begin
          if (byte_count_q == FULL_COUNT) begin
            err_overflow_d = 1'b1;
            state_d        = s_last ? DONE : DRAIN;
          end else begin
            w_en_d       = 1'b1;
            w_addr_d     = addr_q;
            w_data_d     = s_data;
            byte_count_d = byte_count_q + nibble_addr_t'(1);
            // hold at the top address instead of wrapping back to 0
            if (addr_q != LAST_ADDR) begin
              addr_d = addr_q + nibble_addr_t'(2);
            end
            if (s_last) begin
              state_d = DONE;
            end
          end
        end
      end
      DRAIN: begin
        if (abort_hit) begin
          state_d = DONE;
        end else if (accept && s_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d = (state_d != DONE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      s_ready_q      <= 1'b0;
      w_select_q     <= '0;
      w_en_q         <= 1'b0;
      w_addr_q       <= '0;
      w_data_q       <= '0;
      addr_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_overflow_q <= 1'b0;
      err_select_q   <= 1'b0;
      byte_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      s_ready_q      <= s_ready_d;
      w_select_q     <= w_select_d;
      w_en_q         <= w_en_d;
      w_addr_q       <= w_addr_d;
      w_data_q       <= w_data_d;
      addr_q         <= addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_overflow_q <= err_overflow_d;
      err_select_q   <= err_select_d;
      byte_count_q   <= byte_count_d;
    end
  end

  assign w_select     = w_select_q;
  assign w_en         = w_en_q;
  assign w_addr       = w_addr_q;
  assign w_data       = w_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_overflow_q;
  assign err_select   = err_select_q;
  assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_sprite_loader.sv
// tb/tb_sprite_loader.sv - scoreboard bench for sprite_loader
module tb_sprite_loader;
  import sprite_pkg::*;

  typedef struct packed {
    logic [4:0]  sel;
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic [13:0] bc;
    logic        ov;
    logic        es;
    logic [4:0]  sel;
  } dn_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        s_valid, s_ready, s_last, abort;
  logic [7:0]  s_data;
  logic [4:0]  w_select;
  logic        w_en, busy, done, err_overflow, err_select;
  logic [13:0] w_addr, byte_count;
  logic [7:0]  w_data;

  logic        s_valid4, s_ready4, s_last4, abort4;
  logic [7:0]  s_data4;
  logic [4:0]  w_select4;
  logic        w_en4, busy4, done4, err_overflow4, err_select4;
  logic [13:0] w_addr4, byte_count4;
  logic [7:0]  w_data4;

  sprite_loader u_dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .abort(abort),
    .w_select(w_select), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .err_overflow(err_overflow), .err_select(err_select),
    .byte_count(byte_count)
  );

  sprite_loader #(.NUM_SPRITES(4)) u_dut4 (
    .clock(clock), .reset(reset),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4), .s_last(s_last4), .abort(abort4),
    .w_select(w_select4), .w_en(w_en4), .w_addr(w_addr4), .w_data(w_data4),
    .busy(busy4), .done(done4), .err_overflow(err_overflow4), .err_select(err_select4),
    .byte_count(byte_count4)
  );

  wr_t wr_q[$];
  dn_t dn_q[$];
  logic [3:0] mem [int];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rd(input int sel, input int addr);
    int key;
    key = sel * 16384 + addr;
    if (mem.exists(key)) return mem[key];
    return 4'hx;
  endfunction

  task automatic exp_wr(input int sel, input int addr, input int data);
    wr_t e;
    e.sel  = sel[4:0];
    e.addr = addr[13:0];
    e.data = data[7:0];
    wr_q.push_back(e);
  endtask

  task automatic exp_dn(input int bc, input logic ov, input logic es, input int sel);
    dn_t e;
    e.bc  = bc[13:0];
    e.ov  = ov;
    e.es  = es;
    e.sel = sel[4:0];
    dn_q.push_back(e);
  endtask

  // monitor: every write and done pulse is matched against the head of its queue
  wr_t got_w, exp_w;
  dn_t got_d, exp_d;
  always @(negedge clock) begin
    if (!reset) begin
      if (w_en) begin
        got_w = '{sel: w_select, addr: w_addr, data: w_data};
        mem[int'(w_select) * 16384 + int'(w_addr)]     = w_data[3:0];
        mem[int'(w_select) * 16384 + int'(w_addr) + 1] = w_data[7:4];
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'(got_w), 32'hFFFF_FFFF);
        end else begin
          exp_w = wr_q.pop_front();
          chk("write", 32'(got_w), 32'(exp_w));
        end
      end
      if (done) begin
        got_d = '{bc: byte_count, ov: err_overflow, es: err_select, sel: w_select};
        if (dn_q.size() == 0) begin
          chk("unexpected_done", 32'(got_d), 32'hFFFF_FFFF);
        end else begin
          exp_d = dn_q.pop_front();
          chk("done_status", 32'(got_d), 32'(exp_d));
        end
      end
      if (w_en4) begin
        chk("dut4_write", 32'(w_en4), 32'd0);
      end
    end
  end

  task automatic send(input bit t4, input logic [7:0] d, input logic last);
    int n = 0;
    @(negedge clock);
    if (t4) begin
      s_valid4 = 1'b1; s_data4 = d; s_last4 = last;
    end else begin
      s_valid = 1'b1; s_data = d; s_last = last;
    end
    while (!(t4 ? s_ready4 : s_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    s_valid = 1'b0; s_last = 1'b0; s_valid4 = 1'b0; s_last4 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    s_valid = 0; s_data = 0; s_last = 0; abort = 0;
    s_valid4 = 0; s_data4 = 0; s_last4 = 0; abort4 = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_w_en", 32'(w_en), 0);
    chk("rst_w_addr", 32'(w_addr), 0);
    chk("rst_w_data", 32'(w_data), 0);
    chk("rst_w_select", 32'(w_select), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_errs", {30'd0, err_overflow, err_select}, 0);
    chk("rst_byte_count", 32'(byte_count), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_s_ready", 32'(s_ready), 1);

    // 1: two-byte packet into sprite 3
    exp_wr(3, 0, 8'hA5);
    exp_wr(3, 2, 8'h3C);
    exp_dn(2, 0, 0, 3);
    send(0, 8'h03, 0);
    send(0, 8'hA5, 0);
    send(0, 8'h3C, 1);
    idle();
    repeat (3) @(negedge clock);
    chk("t1_nib0", 32'(rd(3, 0)), 32'h5);
    chk("t1_nib1", 32'(rd(3, 1)), 32'hA);
    chk("t1_nib2", 32'(rd(3, 2)), 32'hC);
    chk("t1_nib3", 32'(rd(3, 3)), 32'h3);
    chk("t1_busy", 32'(busy), 0);

    // 2: full sprite, last on byte 8192
    exp_dn(8192, 0, 0, 7);
    send(0, 8'h07, 0);
    for (int i = 0; i < 8192; i++) begin
      exp_wr(7, 2 * i, i & 8'hFF);
      send(0, 8'(i), i == 8191);
    end
    idle();
    repeat (3) @(negedge clock);
    chk("t2_last_addr", 32'(w_addr), 32'd16382);

    // 3: two bytes too many
    exp_dn(8192, 1, 0, 1);
    send(0, 8'h01, 0);
    for (int i = 0; i < 8194; i++) begin
      if (i < 8192) exp_wr(1, 2 * i, (i + 1) & 8'hFF);
      send(0, 8'(i + 1), i == 8193);
    end
    idle();
    repeat (3) @(negedge clock);
    chk("t3_err_overflow_held", 32'(err_overflow), 1);
    chk("t3_addr0_lo", 32'(rd(1, 0)), 32'h1);
    chk("t3_addr0_hi", 32'(rd(1, 1)), 32'h0);

    // 4a: upper header bits ignored, empty packet
    exp_dn(0, 0, 0, 4);
    send(0, 8'hE4, 1);
    idle();
    repeat (3) @(negedge clock);
    chk("t4_w_select", 32'(w_select), 4);
    chk("t4_byte_count", 32'(byte_count), 0);

    // 4b: out-of-range header on a 4-slot loader
    send(1, 8'h04, 0);
    send(1, 8'h11, 0);
    send(1, 8'h22, 1);
    idle();
    n = 0;
    while (!done4 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("t4b_done", 32'(done4), 1);
    chk("t4b_err_select", 32'(err_select4), 1);
    chk("t4b_byte_count", 32'(byte_count4), 0);
    chk("t4b_w_select", 32'(w_select4), 0);

    // 5: abort with the fourth byte
    exp_wr(2, 0, 8'h10);
    exp_wr(2, 2, 8'h11);
    exp_wr(2, 4, 8'h12);
    exp_dn(3, 0, 0, 2);
    send(0, 8'h02, 0);
    send(0, 8'h10, 0);
    send(0, 8'h11, 0);
    send(0, 8'h12, 0);
    @(negedge clock);
    s_valid = 1'b1; s_data = 8'h13; abort = 1'b1;
    #1;
    chk("t5_s_ready_abort", 32'(s_ready), 0);
    @(negedge clock);
    chk("t5_done", 32'(done), 1);
    chk("t5_no_write", 32'(w_en), 0);
    abort = 1'b0; s_valid = 1'b0;
    exp_wr(6, 0, 8'h77);
    exp_dn(1, 0, 0, 6);
    send(0, 8'h06, 0);
    send(0, 8'h77, 1);
    idle();
    repeat (3) @(negedge clock);

    // 6: async reset in the middle of LOAD
    exp_wr(5, 0, 8'h20);
    exp_wr(5, 2, 8'h21);
    exp_wr(5, 4, 8'h22);
    exp_wr(5, 6, 8'h23);
    exp_wr(5, 8, 8'h24);
    send(0, 8'h05, 0);
    for (int i = 0; i < 5; i++) send(0, 8'(8'h20 + i), 0);
    @(negedge clock);
    s_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_w_en", 32'(w_en), 0);
    chk("t6_s_ready", 32'(s_ready), 0);
    chk("t6_byte_count", 32'(byte_count), 0);
    chk("t6_w_select", 32'(w_select), 0);
    @(negedge clock);
    reset = 1'b0;
    exp_wr(9, 0, 8'h11);
    exp_dn(1, 0, 0, 9);
    send(0, 8'h09, 0);
    send(0, 8'h11, 1);
    idle();
    repeat (10) @(negedge clock);

    chk("wr_queue_drained", 32'(wr_q.size()), 0);
    chk("dn_queue_drained", 32'(dn_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
